// File: rtl/conv_pixel_writer_pkg.sv
// Shared types and helpers for the filter datapath writer stage.
// Holds the writer FSM state encoding and the RGB packing function.
package filter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    BORDER = 2'd2,
    DONE   = 2'd3
  } writer_state_t;

  localparam int COLOUR_W = 24;

  // Framebuffer colour word ordering is {red, green, blue}.
  function automatic logic [COLOUR_W-1:0] pack_rgb(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r, g, b};
  endfunction

endpackage

// File: rtl/conv_pixel_writer_if.sv
// Stream-in / framebuffer-write bundle between the convolution stage,
// the pixel writer and the VGA adapter write port.
interface conv_pixel_writer_if #(
  parameter int XW = 8,
  parameter int YW = 7
);
  import filter_pkg::*;

  logic                start;
  logic                in_valid;
  logic [7:0]          red_in;
  logic [7:0]          green_in;
  logic [7:0]          blue_in;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                frame_done;

  modport master (
    output start, in_valid, red_in, green_in, blue_in,
    input  x, y, colour, plot, busy, frame_done
  );

  modport slave (
    input  start, in_valid, red_in, green_in, blue_in,
    output x, y, colour, plot, busy, frame_done
  );

endinterface

// File: rtl/conv_pixel_writer_border_scan.sv
// Border sequencer: walks top row, bottom row, left column, right column
// of the frame, one coordinate per i_go, and flags the final coordinate.
module border_scan #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int XW     = 8,
  parameter int YW     = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clr,
  input  logic          i_go,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last
);

  localparam int CW = (XW > YW) ? XW : YW;

  typedef enum logic [1:0] {
    SEG_TOP   = 2'd0,
    SEG_BOT   = 2'd1,
    SEG_LEFT  = 2'd2,
    SEG_RIGHT = 2'd3
  } seg_t;

  seg_t          r_seg;
  seg_t          w_seg_next;
  logic [CW-1:0] r_pos;
  logic [CW-1:0] w_seg_end;

  // Column segments skip the corners already covered by the two rows.
  always_comb begin
    o_x        = '0;
    o_y        = '0;
    w_seg_end  = '0;
    w_seg_next = SEG_TOP;
    case (r_seg)
      SEG_TOP: begin
        o_x        = r_pos[XW-1:0];
        o_y        = '0;
        w_seg_end  = CW'(WIDTH - 1);
        w_seg_next = SEG_BOT;
      end
      SEG_BOT: begin
        o_x        = r_pos[XW-1:0];
        o_y        = YW'(HEIGHT - 1);
        w_seg_end  = CW'(WIDTH - 1);
        w_seg_next = SEG_LEFT;
      end
      SEG_LEFT: begin
        o_x        = '0;
        o_y        = r_pos[YW-1:0] + YW'(1);
        w_seg_end  = CW'(HEIGHT - 3);
        w_seg_next = SEG_RIGHT;
      end
      SEG_RIGHT: begin
        o_x        = XW'(WIDTH - 1);
        o_y        = r_pos[YW-1:0] + YW'(1);
        w_seg_end  = CW'(HEIGHT - 3);
        w_seg_next = SEG_TOP;
      end
      default: begin
        o_x        = '0;
        o_y        = '0;
        w_seg_end  = '0;
        w_seg_next = SEG_TOP;
      end
    endcase
  end

  assign o_last = (r_seg == SEG_RIGHT) && (r_pos == w_seg_end);

  // Position/segment counter; wraps back to the top-left after the last point.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= SEG_TOP;
      r_pos <= '0;
    end else if (i_clr) begin
      r_seg <= SEG_TOP;
      r_pos <= '0;
    end else if (i_go) begin
      if (r_pos == w_seg_end) begin
        r_pos <= '0;
        r_seg <= w_seg_next;
      end else begin
        r_pos <= r_pos + CW'(1);
      end
    end else begin
      r_pos <= r_pos;
      r_seg <= r_seg;
    end
  end

endmodule

// File: rtl/conv_pixel_writer.sv
// Writes the filtered RGB stream into the framebuffer at window-centre
// positions, then paints the one-pixel frame border black.
module conv_pixel_writer
  import filter_pkg::*;
#(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int XW     = 8,
  parameter int YW     = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  conv_pixel_writer_if.slave bus
);

  writer_state_t       r_state;
  logic [XW-1:0]       r_xi;
  logic [YW-1:0]       r_yi;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_plot;
  logic                r_busy;
  logic                r_done;

  logic                w_centre;
  logic                w_row_end;
  logic                w_frame_end;
  logic [XW-1:0]       w_bx;
  logic [YW-1:0]       w_by;
  logic                w_blast;
  logic                w_scan_go;
  logic                w_scan_clr;

  // A 3x3 window is complete once two full rows and two columns have arrived.
  assign w_centre    = (r_xi >= XW'(2)) && (r_yi >= YW'(2));
  assign w_row_end   = (r_xi == XW'(WIDTH - 1));
  assign w_frame_end = w_row_end && (r_yi == YW'(HEIGHT - 1));
  assign w_scan_go   = (r_state == BORDER);
  assign w_scan_clr  = (r_state == IDLE);

  border_scan #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_border_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_scan_clr),
    .i_go    (w_scan_go),
    .o_x     (w_bx),
    .o_y     (w_by),
    .o_last  (w_blast)
  );

  // Writer FSM with input raster counters and registered write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_xi     <= '0;
      r_yi     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_plot <= 1'b0;
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= STREAM;
            r_xi    <= '0;
            r_yi    <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        STREAM: begin
          if (bus.in_valid) begin
            if (w_centre) begin
              r_plot   <= 1'b1;
              r_x      <= r_xi - XW'(1);
              r_y      <= r_yi - YW'(1);
              r_colour <= pack_rgb(bus.red_in, bus.green_in, bus.blue_in);
            end else begin
              r_plot   <= 1'b0;
            end
            if (w_row_end) begin
              r_xi <= '0;
              r_yi <= r_yi + YW'(1);
            end else begin
              r_xi <= r_xi + XW'(1);
            end
            if (w_frame_end) begin
              r_state <= BORDER;
            end else begin
              r_state <= STREAM;
            end
          end else begin
            r_plot <= 1'b0;
          end
        end
        BORDER: begin
          r_plot   <= 1'b1;
          r_x      <= w_bx;
          r_y      <= w_by;
          r_colour <= '0;
          if (w_blast) begin
            r_state <= DONE;
          end else begin
            r_state <= BORDER;
          end
        end
        DONE: begin
          r_plot  <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_plot  <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.colour     = r_colour;
  assign bus.plot       = r_plot;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;

endmodule

// File: tb/tb_conv_pixel_writer.sv
// Self-checking bench: a 4x3 writer (cycle table + scoreboard scenarios)
// and a default 160x120 writer (full-frame coverage scoreboard).
module tb_conv_pixel_writer;
  import filter_pkg::*;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int SXW = 2;
  localparam int SYW = 2;
  localparam int BW = 160;
  localparam int BH = 120;
  localparam int BXW = 8;
  localparam int BYW = 7;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] c;
  } wr_t;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  pix;
    logic        e_plot;
    int          e_x;
    int          e_y;
    logic [23:0] e_c;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  conv_pixel_writer_if #(.XW(SXW), .YW(SYW)) sbus ();
  conv_pixel_writer_if #(.XW(BXW), .YW(BYW)) bbus ();

  conv_pixel_writer #(.WIDTH(SW), .HEIGHT(SH), .XW(SXW), .YW(SYW)) u_small (
    .clk(clk), .reset_n(reset_n), .bus(sbus)
  );
  conv_pixel_writer #(.WIDTH(BW), .HEIGHT(BH), .XW(BXW), .YW(BYW)) u_big (
    .clk(clk), .reset_n(reset_n), .bus(bbus)
  );

  int   total = 0;
  int   bad = 0;
  wr_t  s_q[$];
  wr_t  b_q[$];
  bit   s_sb_en = 1'b0;
  int   s_plots = 0;
  int   s_dones = 0;
  int   b_plots = 0;
  int   b_dones = 0;
  int   b_dup = 0;
  bit   seen[BW*BH];
  logic [23:0] corner_c = 24'hFFFFFF;
  vec_t tbl[25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input int x, input int y, input logic [23:0] c);
    wr_t w;
    w.x = x;
    w.y = y;
    w.c = c;
    return w;
  endfunction

  task automatic add_exp(input bit big, input int x, input int y, input logic [23:0] c);
    if (big) b_q.push_back(mk(x, y, c));
    else     s_q.push_back(mk(x, y, c));
  endtask

  task automatic push_border(input bit big);
    int w;
    int h;
    w = big ? BW : SW;
    h = big ? BH : SH;
    for (int i = 0; i < w; i++) add_exp(big, i, 0, 24'h0);
    for (int i = 0; i < w; i++) add_exp(big, i, h - 1, 24'h0);
    for (int j = 1; j < h - 1; j++) add_exp(big, 0, j, 24'h0);
    for (int j = 1; j < h - 1; j++) add_exp(big, w - 1, j, 24'h0);
  endtask

  // Small-DUT scoreboard: every plot must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (sbus.frame_done) s_dones++;
    if (sbus.plot) begin
      s_plots++;
      if (s_sb_en) begin
        if (s_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL s_extra_plot: got plot at (%0d,%0d) expected none", sbus.x, sbus.y);
        end else begin
          e = s_q.pop_front();
          check("s_plot_x", 64'(sbus.x), 64'(e.x));
          check("s_plot_y", 64'(sbus.y), 64'(e.y));
          check("s_plot_c", 64'(sbus.colour), 64'(e.c));
        end
      end
    end
  end

  // Big-DUT scoreboard plus per-pixel coverage map.
  always @(negedge clk) begin
    wr_t e;
    int  idx;
    if (bbus.frame_done) b_dones++;
    if (bbus.plot) begin
      b_plots++;
      idx = int'(bbus.y) * BW + int'(bbus.x);
      if (idx < BW * BH) begin
        if (seen[idx]) b_dup++;
        seen[idx] = 1'b1;
      end
      if (int'(bbus.x) == BW - 1 && int'(bbus.y) == BH - 1) corner_c = bbus.colour;
      if (b_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_extra_plot: got plot at (%0d,%0d) expected none", bbus.x, bbus.y);
      end else begin
        e = b_q.pop_front();
        check("b_plot", {8'(bbus.x), 8'(bbus.y), 24'(bbus.colour)},
                        {8'(e.x), 8'(e.y), e.c});
      end
    end
  end

  task automatic wait_small_done(input int d0, input int p0, input int nplots);
    int n;
    n = 0;
    while (s_dones == d0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("s_done_once", 64'(s_dones), 64'(d0 + 1));
    check("s_plot_count", 64'(s_plots), 64'(p0 + nplots));
    check("s_queue_empty", 64'(s_q.size()), 64'd0);
    check("s_busy_after", 64'(sbus.busy), 64'd0);
  endtask

  // One small frame; gap idle cycles between inputs, optional start/valid noise in BORDER.
  task automatic s_frame(input int gap, input bit noise);
    int  d0;
    int  p0;
    bit  ctr;
    d0 = s_dones;
    p0 = s_plots;
    sbus.start = 1'b1;
    @(negedge clk);
    sbus.start = 1'b0;
    for (int k = 0; k < SW * SH; k++) begin
      ctr = ((k % SW) >= 2) && ((k / SW) >= 2);
      sbus.in_valid = 1'b1;
      sbus.red_in   = 8'(k);
      sbus.green_in = 8'(k);
      sbus.blue_in  = 8'(k);
      if (ctr) add_exp(1'b0, (k % SW) - 1, (k / SW) - 1, {8'(k), 8'(k), 8'(k)});
      if (k == SW * SH - 1) push_border(1'b0);
      @(negedge clk);
      sbus.in_valid = 1'b0;
      check("s_centre_latency", 64'(sbus.plot), 64'(ctr));
      if (k != SW * SH - 1) begin
        for (int g = 0; g < gap; g++) @(negedge clk);
      end
    end
    if (noise) begin
      sbus.start    = 1'b1;
      sbus.in_valid = 1'b1;
      sbus.red_in   = 8'hFF;
      repeat (5) @(negedge clk);
      sbus.start    = 1'b0;
      sbus.in_valid = 1'b0;
    end
    wait_small_done(d0, p0, SW * SH);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           d0;
    int           p0;
    int           lx;
    int           ly;
    logic [23:0]  lc;
    wr_t          b;
    int           n;
    int           cov;
    logic [31:0]  kv;

    sbus.start = 1'b0; sbus.in_valid = 1'b0;
    sbus.red_in = 8'h0; sbus.green_in = 8'h0; sbus.blue_in = 8'h0;
    bbus.start = 1'b0; bbus.in_valid = 1'b0;
    bbus.red_in = 8'h0; bbus.green_in = 8'h0; bbus.blue_in = 8'h0;

    // Cycle table for one 4x3 frame: start, 12 pixels, 10 border writes, done, idle.
    tbl[0] = '{1'b1, 1'b0, 8'h0, 1'b0, 0, 0, 24'h0, 1'b1, 1'b0};
    lx = 0; ly = 0; lc = 24'h0;
    for (int k = 0; k < 12; k++) begin
      if ((k % SW) >= 2 && (k / SW) >= 2) begin
        lx = (k % SW) - 1; ly = (k / SW) - 1; lc = {8'(k), 8'(k), 8'(k)};
        tbl[1 + k] = '{1'b0, 1'b1, 8'(k), 1'b1, lx, ly, lc, 1'b1, 1'b0};
      end else begin
        tbl[1 + k] = '{1'b0, 1'b1, 8'(k), 1'b0, lx, ly, lc, 1'b1, 1'b0};
      end
    end
    push_border(1'b0);
    for (int i = 0; i < 10; i++) begin
      b = s_q.pop_front();
      lx = b.x; ly = b.y; lc = b.c;
      tbl[13 + i] = '{1'b0, 1'b0, 8'h0, 1'b1, lx, ly, lc, 1'b1, 1'b0};
    end
    tbl[23] = '{1'b0, 1'b0, 8'h0, 1'b0, lx, ly, lc, 1'b0, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 8'h0, 1'b0, lx, ly, lc, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_s_plot", 64'(sbus.plot), 64'd0);
    check("rst_s_busy", 64'(sbus.busy), 64'd0);
    check("rst_s_done", 64'(sbus.frame_done), 64'd0);
    check("rst_s_xyc", {8'(sbus.x), 8'(sbus.y), 24'(sbus.colour)}, 64'd0);
    check("rst_b_plot_busy", {62'd0, bbus.plot, bbus.busy}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      sbus.start    = tbl[i].start;
      sbus.in_valid = tbl[i].valid;
      sbus.red_in   = tbl[i].pix;
      sbus.green_in = tbl[i].pix;
      sbus.blue_in  = tbl[i].pix;
      @(negedge clk);
      check($sformatf("tbl%0d_plot", i), 64'(sbus.plot), 64'(tbl[i].e_plot));
      check($sformatf("tbl%0d_x", i), 64'(sbus.x), 64'(tbl[i].e_x));
      check($sformatf("tbl%0d_y", i), 64'(sbus.y), 64'(tbl[i].e_y));
      check($sformatf("tbl%0d_c", i), 64'(sbus.colour), 64'(tbl[i].e_c));
      check($sformatf("tbl%0d_busy", i), 64'(sbus.busy), 64'(tbl[i].e_busy));
      check($sformatf("tbl%0d_done", i), 64'(sbus.frame_done), 64'(tbl[i].e_done));
    end
    sbus.in_valid = 1'b0;
    s_sb_en = 1'b1;

    s_frame(1, 1'b0);
    s_frame(0, 1'b1);

    // Asynchronous reset while input 7 is on the bus.
    d0 = s_dones;
    sbus.start = 1'b1;
    @(negedge clk);
    sbus.start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      sbus.in_valid = 1'b1;
      sbus.red_in = 8'(k); sbus.green_in = 8'(k); sbus.blue_in = 8'(k);
      @(negedge clk);
    end
    sbus.in_valid = 1'b1;
    sbus.red_in = 8'd7; sbus.green_in = 8'd7; sbus.blue_in = 8'd7;
    #2 reset_n = 1'b0;
    #1;
    check("abort_plot", 64'(sbus.plot), 64'd0);
    check("abort_busy", 64'(sbus.busy), 64'd0);
    check("abort_done", 64'(sbus.frame_done), 64'd0);
    check("abort_xyc", {8'(sbus.x), 8'(sbus.y), 24'(sbus.colour)}, 64'd0);
    sbus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(s_dones), 64'(d0));
    check("abort_idle_busy", 64'(sbus.busy), 64'd0);
    s_frame(0, 1'b0);

    // Valid data in IDLE without start is ignored.
    p0 = s_plots;
    for (int k = 0; k < 5; k++) begin
      sbus.in_valid = 1'b1;
      sbus.red_in = 8'(k + 40);
      @(negedge clk);
      check("idle_busy", 64'(sbus.busy), 64'd0);
    end
    sbus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_plots", 64'(s_plots), 64'(p0));

    // Full default-size frame.
    bbus.start = 1'b1;
    @(negedge clk);
    bbus.start = 1'b0;
    for (int k = 0; k < BW * BH; k++) begin
      kv = 32'(k);
      bbus.in_valid = 1'b1;
      bbus.red_in   = kv[7:0];
      bbus.green_in = kv[15:8];
      bbus.blue_in  = kv[7:0] ^ 8'h5A;
      if ((k % BW) >= 2 && (k / BW) >= 2)
        add_exp(1'b1, (k % BW) - 1, (k / BW) - 1, {kv[7:0], kv[15:8], kv[7:0] ^ 8'h5A});
      if (k == BW * BH - 1) push_border(1'b1);
      @(negedge clk);
    end
    bbus.in_valid = 1'b0;
    n = 0;
    while (b_dones == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    cov = 0;
    for (int i = 0; i < BW * BH; i++) if (seen[i]) cov++;
    check("big_done_once", 64'(b_dones), 64'd1);
    check("big_plot_count", 64'(b_plots), 64'd19200);
    check("big_coverage", 64'(cov), 64'd19200);
    check("big_duplicates", 64'(b_dup), 64'd0);
    check("big_corner_black", 64'(corner_c), 64'd0);
    check("big_queue_empty", 64'(b_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_pixel_writer.md
# conv_pixel_writer

Downstream stage of the filter datapath: consumes the filtered RGB stream from the convolution stage and writes it into the VGA framebuffer through the adapter's `x`/`y`/`colour`/`plot` write port. It tracks the raster position of the incoming stream and maps each 3x3 window result to its centre pixel. Once the last input of a frame has arrived, it paints the one-pixel frame border (which has no valid window) black. It pulses `frame_done` when every pixel of the frame has been written exactly once.

## Interface
Parameters:
- `WIDTH`, 160, frame width in pixels (≥3)
- `HEIGHT`, 120, frame height in pixels (≥3)
- `XW`, 8, x coordinate width (≥ clog2(WIDTH))
- `YW`, 7, y coordinate width (≥ clog2(HEIGHT))

Ports:
- `clk`  in  1  system clock; one clock domain only
- `reset_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a frame; sampled in IDLE only
- `in_valid`  in  1  `red_in`/`green_in`/`blue_in` carry one filtered pixel this cycle
- `red_in`, `green_in`, `blue_in`  in  8 each  filtered channel values
- `x`  out  XW  framebuffer x
- `y`  out  YW  framebuffer y
- `colour`  out  24  {red, green, blue}
- `plot`  out  1  write strobe; x/y/colour valid when high
- `busy`  out  1  high in STREAM or BORDER
- `frame_done`  out  1  one-cycle pulse at end of frame

## Operation
- FSM states: IDLE, STREAM, BORDER, DONE.
- IDLE: `start`=1 → STREAM; input counters `xi`, `yi` cleared to 0. `in_valid` is ignored in IDLE.
- STREAM: each `in_valid` cycle consumes one pixel at (`xi`,`yi`), raster order.
  - `xi` wraps WIDTH-1→0 with `yi`+1.
  - If `xi`≥2 and `yi`≥2: write (`xi`-1, `yi`-1) with colour {r,g,b}.
  - All other inputs are consumed without a write.
  - The input at (WIDTH-1, HEIGHT-1) is the last of the frame → BORDER.
- BORDER: one black write (colour 0) per cycle, unconditionally, in this order:
  - top row: y=0, x=0..WIDTH-1
  - bottom row: y=HEIGHT-1, x=0..WIDTH-1
  - left column: x=0, y=1..HEIGHT-2
  - right column: x=WIDTH-1, y=1..HEIGHT-2
  - Total 2·WIDTH+2·(HEIGHT-2) writes. After the last one → DONE.
- DONE: `frame_done`=1 for one cycle → IDLE.
- `start` in STREAM, BORDER or DONE is ignored. `in_valid` in BORDER or DONE is dropped; there is no backpressure.
- Write count per frame: (WIDTH-2)(HEIGHT-2) centre writes + border writes = WIDTH·HEIGHT, with no duplicates.

## Timing
- Reset: state IDLE; `x`, `y`, `colour`, `plot`, `busy`, `frame_done` all 0; counters 0.
- Asynchronous reset mid-frame aborts immediately. No `frame_done` is issued, and no partial frame is resumed.
- All outputs are registered.
- Centre write latency: `plot` is high the cycle after the accepted `in_valid`.
- Cycle after the last input: first BORDER write appears (top-left, colour 0). Border writes are back-to-back, one per cycle.
- `frame_done` is high the cycle after the final border write's `plot`. `plot` is 0 in that cycle.
- `busy` rises the cycle after `start` and falls with `frame_done`.
- `x`/`y`/`colour` hold their last value when `plot`=0.

## Structure
- Shared package `filter_pkg`:
  - `writer_state_t` enum (IDLE, STREAM, BORDER, DONE)
  - `COLOUR_W`=24
  - a `pack_rgb` function
- Sub-module `border_scan`: a counter/segment sequencer producing border x/y and a `last` flag from `go`. Parameterised by WIDTH, HEIGHT, XW, YW.
- Top level holds the FSM, input counters, centre mapping and the output register mux.

## Test plan
Run with WIDTH=4, HEIGHT=3 unless noted.
- Reset, then `start` plus 12 back-to-back valid pixels with colour = index:
  - centre plots (1,1) colour 0x0A0A0A and (2,1) colour 0x0B0B0B
  - then 10 black plots in the specified order
  - `frame_done` one cycle after the 10th; 12 plots total
- Same frame with `in_valid` gapped every other cycle: identical plot sequence, each centre plot the cycle after its input.
- `start` and `in_valid` asserted mid-BORDER: no extra plots, no restart, `frame_done` occurs once.
- `reset_n` low during input 7: outputs 0 immediately, no `frame_done`. New `start` → full correct frame.
- Default 160×120 full frame: 18644 centre plots + 556 border plots = 19200. Scoreboard covers every pixel exactly once, and the (159,119) write is black.
- `in_valid` in IDLE without `start`: no plots, `busy` stays 0.
